// File: rtl/computer_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : computer_run_ctrl
// Purpose  : Hack core run control (reset sequencing, run/halt/step,
//            PC breakpoint, cycle limit) and memory-mapped LED capture.
// Revision : 1.0 - initial release
// ============================================================================
module computer_run_ctrl #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 15,
   parameter int unsigned PC_WIDTH      = 15,
   parameter int unsigned NUM_CHANNELS  = 1,
   parameter int unsigned OUT_BASE_ADDR = 'h6001,
   parameter int unsigned RESET_CYCLES  = 1,
   parameter int unsigned AUTO_RUN      = 1,
   parameter int unsigned CYCLE_WIDTH   = 32,
   parameter int unsigned MAX_CYCLES    = 0
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               run,
   input  logic                               halt,
   input  logic                               step,
   input  logic                               bp_enable,
   input  logic [PC_WIDTH-1:0]                bp_addr,
   input  logic [PC_WIDTH-1:0]                pc,
   input  logic                               mem_write,
   input  logic [ADDR_WIDTH-1:0]              mem_addr,
   input  logic [DATA_WIDTH-1:0]              mem_data,
   output logic                               cpu_reset,
   output logic                               cpu_enable,
   output logic [1:0]                         state,
   output logic [CYCLE_WIDTH-1:0]             cycle_count,
   output logic                               bp_hit,
   output logic                               limit_hit,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] led_output
);

   localparam int                      c_RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [c_RCW-1:0]        c_RST_LAST = c_RCW'(RESET_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0]   c_BASE     = ADDR_WIDTH'(OUT_BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0]   c_NCH      = ADDR_WIDTH'(NUM_CHANNELS);
   localparam logic [CYCLE_WIDTH-1:0]  c_MAX      = CYCLE_WIDTH'(MAX_CYCLES);

   typedef enum logic [1:0] {
      S_RESET   = 2'd0,
      S_HALTED  = 2'd1,
      S_RUNNING = 2'd2,
      S_STEP    = 2'd3
   } state_t;

   state_t                            state_q, state_d;
   logic [c_RCW-1:0]                  rst_cnt_q, rst_cnt_d;
   logic [CYCLE_WIDTH-1:0]            cycle_q;
   logic                              bp_hit_q, bp_hit_d;
   logic                              limit_hit_q, limit_hit_d;
   logic                              bp_skip_q, bp_skip_d;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] led_q;

   logic                              w_bp_match;
   logic                              w_cpu_en;
   logic                              w_sat;
   logic [CYCLE_WIDTH-1:0]            w_cyc_inc;
   logic                              w_limit_event;
   logic [ADDR_WIDTH-1:0]             w_offset;
   logic                              w_wr_en;
   logic [NUM_CHANNELS-1:0]           w_ch_sel;

   // bp_skip lets a resumed run execute the instruction it stopped on.
   assign w_bp_match    = bp_enable && (pc == bp_addr) && !bp_skip_q;
   assign w_cpu_en      = (state_q == S_STEP) || ((state_q == S_RUNNING) && !w_bp_match);
   assign w_sat         = &cycle_q;
   assign w_cyc_inc     = cycle_q + CYCLE_WIDTH'(1);
   assign w_limit_event = (MAX_CYCLES != 0) && w_cpu_en && !w_sat && (w_cyc_inc == c_MAX);

   assign w_offset = mem_addr - c_BASE;
   assign w_wr_en  = w_cpu_en && mem_write && (mem_addr >= c_BASE) && (w_offset < c_NCH);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch_sel
      assign w_ch_sel[i] = w_wr_en && (w_offset == ADDR_WIDTH'(i));
   end

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      bp_hit_d    = bp_hit_q;
      limit_hit_d = limit_hit_q;
      bp_skip_d   = bp_skip_q;

      if (w_limit_event) begin
         limit_hit_d = 1'b1;
      end

      unique case (state_q)
         S_RESET: begin
            if (rst_cnt_q == c_RST_LAST) begin
               state_d = (AUTO_RUN != 0) ? S_RUNNING : S_HALTED;
            end else begin
               rst_cnt_d = rst_cnt_q + c_RCW'(1);
            end
         end
         S_HALTED: begin
            if (!limit_hit_q) begin
               if (run) begin
                  state_d   = S_RUNNING;
                  bp_hit_d  = 1'b0;
                  bp_skip_d = 1'b1;
               end else if (step) begin
                  state_d  = S_STEP;
                  bp_hit_d = 1'b0;
               end
            end
         end
         S_STEP: begin
            state_d = S_HALTED;
         end
         S_RUNNING: begin
            bp_skip_d = 1'b0;
            if (w_bp_match) begin
               bp_hit_d = 1'b1;
            end
            if (halt || w_bp_match || w_limit_event) begin
               state_d = S_HALTED;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_RESET;
         rst_cnt_q   <= '0;
         cycle_q     <= '0;
         bp_hit_q    <= 1'b0;
         limit_hit_q <= 1'b0;
         bp_skip_q   <= 1'b0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         bp_hit_q    <= bp_hit_d;
         limit_hit_q <= limit_hit_d;
         bp_skip_q   <= bp_skip_d;
         if (w_cpu_en && !w_sat) begin
            cycle_q <= w_cyc_inc;
         end
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_ch_sel[i]) begin
               led_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_data;
            end
         end
      end
   end

   assign cpu_reset   = (state_q == S_RESET);
   assign cpu_enable  = w_cpu_en;
   assign state       = state_q;
   assign cycle_count = cycle_q;
   assign bp_hit      = bp_hit_q;
   assign limit_hit   = limit_hit_q;
   assign led_output  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_computer_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_computer_run_ctrl
// Purpose  : Scoreboard bench for computer_run_ctrl (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_computer_run_ctrl;

   localparam int K_CRST = 0;
   localparam int K_EN   = 1;
   localparam int K_ST   = 2;
   localparam int K_CYC  = 3;
   localparam int K_BP   = 4;
   localparam int K_LIM  = 5;
   localparam int K_LED  = 6;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, run, halt, step, bp_en, mw;
   logic [14:0] bp_addr, pc, ma;
   logic [15:0] md;

   logic        a_crst, a_en, a_bp, a_lim;
   logic [1:0]  a_st;
   logic [31:0] a_cyc;
   logic [63:0] a_led;
   logic        b_crst, b_en, b_bp, b_lim;
   logic [1:0]  b_st;
   logic [31:0] b_cyc;
   logic [15:0] b_led;

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cur    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   always #5 clk = ~clk;

   computer_run_ctrl #(.NUM_CHANNELS(4)) u_a (
      .clock(clk), .reset(rst_a), .run(run), .halt(halt), .step(step),
      .bp_enable(bp_en), .bp_addr(bp_addr), .pc(pc),
      .mem_write(mw), .mem_addr(ma), .mem_data(md),
      .cpu_reset(a_crst), .cpu_enable(a_en), .state(a_st), .cycle_count(a_cyc),
      .bp_hit(a_bp), .limit_hit(a_lim), .led_output(a_led)
   );

   computer_run_ctrl #(.RESET_CYCLES(3), .AUTO_RUN(0), .MAX_CYCLES(5)) u_b (
      .clock(clk), .reset(rst_b), .run(run), .halt(halt), .step(step),
      .bp_enable(bp_en), .bp_addr(bp_addr), .pc(pc),
      .mem_write(mw), .mem_addr(ma), .mem_data(md),
      .cpu_reset(b_crst), .cpu_enable(b_en), .state(b_st), .cycle_count(b_cyc),
      .bp_hit(b_bp), .limit_hit(b_lim), .led_output(b_led)
   );

   function automatic logic [63:0] observe(input int sel);
      logic [63:0] v;
      v = '1;
      if (cur == 0) begin
         case (sel)
            K_CRST:  v = {63'd0, a_crst};
            K_EN:    v = {63'd0, a_en};
            K_ST:    v = {62'd0, a_st};
            K_CYC:   v = {32'd0, a_cyc};
            K_BP:    v = {63'd0, a_bp};
            K_LIM:   v = {63'd0, a_lim};
            K_LED:   v = a_led;
            default: v = '1;
         endcase
      end else begin
         case (sel)
            K_CRST:  v = {63'd0, b_crst};
            K_EN:    v = {63'd0, b_en};
            K_ST:    v = {62'd0, b_st};
            K_CYC:   v = {32'd0, b_cyc};
            K_BP:    v = {63'd0, b_bp};
            K_LIM:   v = {63'd0, b_lim};
            K_LED:   v = {48'd0, b_led};
            default: v = '1;
         endcase
      end
      return v;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic expect_st(input string tag, input logic [1:0] st, input logic en, input logic [31:0] cyc);
      expect_val({tag, ".state"}, K_ST, {62'd0, st});
      expect_val({tag, ".en"}, K_EN, {63'd0, en});
      expect_val({tag, ".cyc"}, K_CYC, {32'd0, cyc});
   endtask

   task automatic sample();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
      bp_en = 1'b0; bp_addr = 15'd10; pc = '0; mw = 1'b0; ma = '0; md = '0;

      // ---------------- instance A: defaults with four channels ----------------
      cur = 0;
      tick();
      expect_st("a_rst", 2'd0, 1'b0, 32'd0);
      expect_val("a_rst.crst", K_CRST, 64'd1);
      expect_val("a_rst.led", K_LED, 64'd0);
      expect_val("a_rst.bp", K_BP, 64'd0);
      expect_val("a_rst.lim", K_LIM, 64'd0);
      sample();
      rst_a = 1'b1;
      expect_val("a_seq.crst", K_CRST, 64'd1);
      expect_val("a_seq.state", K_ST, 64'd0);
      sample();
      tick();
      expect_st("a_run", 2'd2, 1'b1, 32'd0);
      expect_val("a_run.crst", K_CRST, 64'd0);
      sample();
      repeat (128) tick();
      expect_st("a_128", 2'd2, 1'b1, 32'd128);
      expect_val("a_128.led", K_LED, 64'd0);
      sample();

      mw = 1'b1; ma = 15'h6003; md = 16'hBEEF;
      expect_val("a_wr_pre.led", K_LED, 64'd0);
      sample();
      tick();
      expect_val("a_wr_ch2", K_LED, 64'h0000_BEEF_0000_0000);
      sample();
      ma = 15'h6005; md = 16'h1234;
      tick();
      expect_val("a_wr_above", K_LED, 64'h0000_BEEF_0000_0000);
      sample();
      ma = 15'h6000; md = 16'hFFFF;
      tick();
      expect_val("a_wr_below", K_LED, 64'h0000_BEEF_0000_0000);
      sample();
      ma = 15'h6004; md = 16'hA5A5;
      tick();
      expect_val("a_wr_ch3", K_LED, 64'hA5A5_BEEF_0000_0000);
      sample();
      ma = 15'h6001; md = 16'h1111;
      tick();
      expect_val("a_wr_ch0", K_LED, 64'hA5A5_BEEF_0000_1111);
      expect_val("a_wr_ch0.cyc", K_CYC, 64'd133);
      sample();

      mw = 1'b0; halt = 1'b1;
      expect_st("a_halt_req", 2'd2, 1'b1, 32'd133);
      sample();
      tick();
      halt = 1'b0;
      expect_st("a_halted", 2'd1, 1'b0, 32'd134);
      sample();
      mw = 1'b1; ma = 15'h6001; md = 16'hDEAD;
      tick();
      mw = 1'b0;
      expect_val("a_wr_disabled", K_LED, 64'hA5A5_BEEF_0000_1111);
      expect_val("a_wr_disabled.cyc", K_CYC, 64'd134);
      sample();

      bp_en = 1'b1; pc = 15'd9; run = 1'b1;
      tick();
      run = 1'b0;
      expect_st("a_resume", 2'd2, 1'b1, 32'd134);
      sample();
      tick();
      pc = 15'd10;
      expect_st("a_bp_cycle", 2'd2, 1'b0, 32'd135);
      sample();
      tick();
      expect_st("a_bp_halt", 2'd1, 1'b0, 32'd135);
      expect_val("a_bp_halt.bp", K_BP, 64'd1);
      sample();
      run = 1'b1;
      tick();
      run = 1'b0;
      expect_st("a_bp_skip", 2'd2, 1'b1, 32'd135);
      expect_val("a_bp_skip.bp", K_BP, 64'd0);
      sample();
      tick();
      pc = 15'd11;
      expect_st("a_after_bp", 2'd2, 1'b1, 32'd136);
      sample();
      pc = 15'd10; halt = 1'b1;
      expect_val("a_bp_halt2.en", K_EN, 64'd0);
      sample();
      tick();
      halt = 1'b0;
      expect_st("a_halt_bp", 2'd1, 1'b0, 32'd136);
      expect_val("a_halt_bp.bp", K_BP, 64'd1);
      sample();
      step = 1'b1;
      tick();
      step = 1'b0;
      expect_st("a_step_at_bp", 2'd3, 1'b1, 32'd136);
      expect_val("a_step_at_bp.bp", K_BP, 64'd0);
      sample();
      tick();
      expect_st("a_step_done", 2'd1, 1'b0, 32'd137);
      sample();

      bp_en = 1'b0; run = 1'b1;
      tick();
      run = 1'b0; mw = 1'b1; ma = 15'h6002; md = 16'h7777; rst_a = 1'b0;
      expect_val("a_rst_run.en", K_EN, 64'd1);
      sample();
      tick();
      expect_st("a_rst_mid", 2'd0, 1'b0, 32'd0);
      expect_val("a_rst_mid.crst", K_CRST, 64'd1);
      expect_val("a_rst_mid.led", K_LED, 64'd0);
      sample();

      // ------- instance B: AUTO_RUN=0, RESET_CYCLES=3, MAX_CYCLES=5 -------
      cur = 1;
      mw = 1'b0; rst_b = 1'b1;
      expect_val("b_seq0.crst", K_CRST, 64'd1);
      sample();
      tick();
      expect_val("b_seq1.state", K_ST, 64'd0);
      sample();
      tick();
      expect_val("b_seq2.crst", K_CRST, 64'd1);
      sample();
      tick();
      expect_st("b_halted", 2'd1, 1'b0, 32'd0);
      expect_val("b_halted.crst", K_CRST, 64'd0);
      sample();

      for (int k = 1; k <= 3; k++) begin
         step = 1'b1;
         expect_val($sformatf("b_step%0d_pre.en", k), K_EN, 64'd0);
         sample();
         tick();
         step = 1'b0;
         if (k == 1) begin
            mw = 1'b1; ma = 15'h6001; md = 16'hC0DE;
         end
         expect_st($sformatf("b_step%0d", k), 2'd3, 1'b1, 32'(k - 1));
         sample();
         tick();
         mw = 1'b0;
         expect_st($sformatf("b_step%0d_done", k), 2'd1, 1'b0, 32'(k));
         sample();
      end
      expect_val("b_step_wr", K_LED, 64'h0000_0000_0000_C0DE);
      sample();
      mw = 1'b1; md = 16'h0BAD;
      tick();
      mw = 1'b0;
      expect_val("b_halt_wr", K_LED, 64'h0000_0000_0000_C0DE);
      sample();

      run = 1'b1; step = 1'b1;
      tick();
      run = 1'b0; step = 1'b0;
      expect_st("b_run_prio", 2'd2, 1'b1, 32'd3);
      sample();
      tick();
      expect_st("b_run4", 2'd2, 1'b1, 32'd4);
      sample();
      tick();
      expect_st("b_limit", 2'd1, 1'b0, 32'd5);
      expect_val("b_limit.lim", K_LIM, 64'd1);
      sample();
      run = 1'b1;
      tick();
      run = 1'b0; step = 1'b1;
      expect_st("b_lim_run", 2'd1, 1'b0, 32'd5);
      sample();
      tick();
      step = 1'b0;
      expect_st("b_lim_step", 2'd1, 1'b0, 32'd5);
      expect_val("b_lim_step.lim", K_LIM, 64'd1);
      sample();
      rst_b = 1'b0;
      tick();
      expect_st("b_clr", 2'd0, 1'b0, 32'd0);
      expect_val("b_clr.lim", K_LIM, 64'd0);
      expect_val("b_clr.led", K_LED, 64'd0);
      sample();

      rst_b = 1'b1;
      repeat (3) tick();
      step = 1'b1;
      tick();
      step = 1'b0; mw = 1'b1; ma = 15'h6001; md = 16'h5555; rst_b = 1'b0;
      expect_st("b_in_step", 2'd3, 1'b1, 32'd0);
      sample();
      tick();
      mw = 1'b0;
      expect_st("b_rst_step", 2'd0, 1'b0, 32'd0);
      expect_val("b_rst_step.led", K_LED, 64'd0);
      sample();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
